// File: rtl/cpu_io_bridge.sv
// CPU memory-bus bridge: decodes RAM vs. memory-mapped I/O and returns read data one cycle late.
// It also owns the UART TX FIFO, the free-running cycle counter and the sticky program-stop flag.
module cpu_io_bridge #(
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 4,
    parameter int RAM_AW      = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [7:0]        cpu_dout,
    input  logic [31:0]       cpu_a,
    input  logic              cpu_wr,
    output logic [7:0]        cpu_din,
    output logic              io_buffer_full,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_pop,
    output logic              program_finish,
    output logic              tx_overflow
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    logic          io_sel, hit_uart, hit_stop, hit_cnt;
    logic          rd_acc, wr_acc;
    logic          push_req, push, pop, full, drop;
    logic [7:0]    push_data, io_rd_byte;
    logic [CW-1:0] count, count_next;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [31:0]   cyc_cnt, snap;
    logic          rd_pend, rd_is_ram;
    logic [7:0]    io_byte, din_hold;

    assign io_sel   = (cpu_a[17:16] == 2'b11);
    assign hit_uart = io_sel & (cpu_a[15:0] == 16'h0000);
    assign hit_stop = io_sel & (cpu_a[15:0] == 16'h0004);
    assign hit_cnt  = io_sel & (cpu_a[15:2] == 14'h0001);
    assign rd_acc   = rdy_in & ~cpu_wr;
    assign wr_acc   = rdy_in & cpu_wr;

    assign ram_a    = cpu_a[RAM_AW-1:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = rdy_in & cpu_wr & ~io_sel;
    assign rx_pop   = rd_acc & hit_uart & rx_valid;

    // TX handshake: a byte moves to the UART on every cycle where tx_valid and
    // tx_ready are both high; tx_data is stable while tx_valid is high and not taken.
    assign tx_valid  = (count != '0);
    assign tx_data   = tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign pop       = tx_valid & tx_ready;
    assign full      = (count == CW'(TX_DEPTH));
    assign push_req  = wr_acc & ((hit_uart & (cpu_dout != 8'h00)) | hit_stop);
    assign push_data = hit_stop ? 8'h00 : cpu_dout;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign push       = push_req & (~full | pop);
    assign drop       = push_req & full & ~pop;
    assign count_next = count + CW'(push) - CW'(pop);

    always_comb begin
        io_rd_byte = 8'h00;
        if (hit_uart) begin
            io_rd_byte = rx_valid ? rx_data : 8'h00;
        end else if (hit_cnt) begin
            case (cpu_a[1:0])
                2'd0:    io_rd_byte = cyc_cnt[7:0];
                2'd1:    io_rd_byte = snap[15:8];
                2'd2:    io_rd_byte = snap[23:16];
                default: io_rd_byte = snap[31:24];
            endcase
        end
    end

    // Outside the cycle right after a read, cpu_din replays the last value shown.
    assign cpu_din = rd_pend ? (rd_is_ram ? ram_din : io_byte) : din_hold;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            io_buffer_full <= 1'b0;
            tx_overflow    <= 1'b0;
            program_finish <= 1'b0;
            cyc_cnt        <= 32'd0;
            snap           <= 32'd0;
            rd_pend        <= 1'b0;
            rd_is_ram      <= 1'b1;
            io_byte        <= 8'h00;
            din_hold       <= 8'h00;
        end else begin
            count          <= count_next;
            io_buffer_full <= (count_next >= CW'(TX_DEPTH - FULL_MARGIN));
            din_hold       <= cpu_din;
            rd_pend        <= rd_acc;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (drop) tx_overflow <= 1'b1;
            if (wr_acc & hit_stop) program_finish <= 1'b1;
            if (rdy_in) cyc_cnt <= cyc_cnt + 32'd1;
            if (rd_acc) begin
                rd_is_ram <= ~io_sel;
                io_byte   <= io_rd_byte;
                if (hit_cnt & (cpu_a[1:0] == 2'd0)) snap <= cyc_cnt;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo_mem[wr_ptr] <= push_data;
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed bench for cpu_io_bridge: RAM path, TX FIFO, thresholds, cycle counter,
// rdy_in gating, RX reads, program stop and asynchronous reset.
module tb_cpu_io_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [7:0]  cpu_dout;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_finish;
    logic        tx_overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram_mem [0:131071];
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    cpu_io_bridge #(.TX_DEPTH(16), .FULL_MARGIN(4), .RAM_AW(17)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .cpu_dout(cpu_dout), .cpu_a(cpu_a),
        .cpu_wr(cpu_wr), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .program_finish(program_finish), .tx_overflow(tx_overflow)
    );

    // Synchronous RAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    // Record every byte the UART side accepts.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) got_q.push_back(tx_data);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
        rdy = r; cpu_wr = w; cpu_a = a; cpu_dout = d;
    endtask

    task automatic do_reset();
        bus(1'b0, 1'b0, 32'h0, 8'h00);
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({cpu_din, tx_data} !== 16'h0000) begin
            errors++; $display("FAIL reset_data: cpu_din=%h tx_data=%h expected 00 00", cpu_din, tx_data);
        end
        checks++;
        if ({io_buffer_full, tx_valid, program_finish, tx_overflow, ram_we, rx_pop} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: ibf=%b txv=%b pf=%b ovf=%b we=%b pop=%b expected all 0",
                     io_buffer_full, tx_valid, program_finish, tx_overflow, ram_we, rx_pop);
        end
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_ram();
        bus(1'b1, 1'b1, 32'h0000_0100, 8'h41);
        #1;
        checks++;
        if ({ram_we, ram_a, ram_dout} !== {1'b1, 17'h00100, 8'h41}) begin
            errors++; $display("FAIL ram_write: we=%b a=%h d=%h expected 1 00100 41", ram_we, ram_a, ram_dout);
        end
        cycle();
        bus(1'b1, 1'b0, 32'h0000_0100, 8'h00);
        #1;
        checks++;
        if ({ram_we, cpu_din} !== {1'b0, 8'h00}) begin
            errors++; $display("FAIL ram_read_early: we=%b din=%h expected 0 00", ram_we, cpu_din);
        end
        cycle();
        bus(1'b0, 1'b0, 32'h0, 8'h00);
        checks++;
        if (cpu_din !== 8'h41) begin
            errors++; $display("FAIL ram_read: cpu_din=%h expected 41", cpu_din);
        end
        cycle();
        cycle();
        checks++;
        if (cpu_din !== 8'h41) begin
            errors++; $display("FAIL ram_read_hold: cpu_din=%h expected 41", cpu_din);
        end
    endtask

    task automatic test_tx_basic();
        int start;
        do_reset();
        tx_ready = 1'b1;
        start = got_q.size();
        exp_q = '{8'h48, 8'h69};
        bus(1'b1, 1'b1, 32'h0003_0000, 8'h48); cycle();
        bus(1'b1, 1'b1, 32'h0003_0000, 8'h00); cycle();
        bus(1'b1, 1'b1, 32'h0003_0000, 8'h69); cycle();
        bus(1'b0, 1'b0, 32'h0, 8'h00);
        repeat (5) cycle();
        checks++;
        if (got_q.size() - start !== exp_q.size()) begin
            errors++; $display("FAIL tx_basic_count: got %0d bytes expected %0d", got_q.size() - start, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[start+i] !== exp_q[i]) begin
                    errors++; $display("FAIL tx_basic_byte%0d: got %h expected %h", i, got_q[start+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        int start;
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            bus(1'b1, 1'b1, 32'h0003_0000, 8'h55);
            cycle();
            if (i == 11) begin
                checks++;
                if (io_buffer_full !== 1'b0) begin
                    errors++; $display("FAIL ibf_after_11: got %b expected 0", io_buffer_full);
                end
            end
            if (i == 12) begin
                checks++;
                if (io_buffer_full !== 1'b1) begin
                    errors++; $display("FAIL ibf_after_12: got %b expected 1", io_buffer_full);
                end
            end
        end
        checks++;
        if (tx_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_at_16: got %b expected 0", tx_overflow);
        end
        cycle();
        checks++;
        if ({tx_overflow, io_buffer_full, tx_valid} !== 3'b111) begin
            errors++; $display("FAIL ovf_at_17: ovf=%b ibf=%b txv=%b expected 1 1 1", tx_overflow, io_buffer_full, tx_valid);
        end
        start = got_q.size();
        tx_ready = 1'b1;
        bus(1'b1, 1'b1, 32'h0003_0000, 8'h66);
        cycle();
        bus(1'b0, 1'b0, 32'h0, 8'h00);
        checks++;
        if (io_buffer_full !== 1'b1) begin
            errors++; $display("FAIL ibf_push_pop_full: got %b expected 1", io_buffer_full);
        end
        repeat (20) cycle();
        checks++;
        if (got_q.size() - start !== 17) begin
            errors++; $display("FAIL full_drain_count: got %0d bytes expected 17", got_q.size() - start);
        end else begin
            checks++;
            if (got_q[start+16] !== 8'h66 || got_q[start] !== 8'h55 || got_q[start+15] !== 8'h55) begin
                errors++; $display("FAIL full_drain_order: first=%h 16th=%h last=%h expected 55 55 66",
                                   got_q[start], got_q[start+15], got_q[start+16]);
            end
        end
        checks++;
        if ({io_buffer_full, tx_valid} !== 2'b00) begin
            errors++; $display("FAIL full_drained: ibf=%b txv=%b expected 0 0", io_buffer_full, tx_valid);
        end
    endtask

    task automatic counter_case(input int n, input logic [7:0] e0, input logic [7:0] e1,
                                input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_b [4];
        exp_b = '{e0, e1, e2, e3};
        do_reset();
        repeat (n) begin
            bus(1'b1, 1'b0, 32'h0003_000C, 8'h00);
            cycle();
        end
        for (int k = 0; k < 4; k++) begin
            bus(1'b1, 1'b0, 32'h0003_0004 + k, 8'h00);
            cycle();
            checks++;
            if (cpu_din !== exp_b[k]) begin
                errors++; $display("FAIL counter_%0h_byte%0d: got %h expected %h", n, k, cpu_din, exp_b[k]);
            end
        end
    endtask

    task automatic test_counter();
        counter_case(32'h1234, 8'h34, 8'h12, 8'h00, 8'h00);
        counter_case(32'h00FF, 8'hFF, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_rdy_gating();
        do_reset();
        repeat (5) begin
            bus(1'b1, 1'b0, 32'h0003_000C, 8'h00);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            bus(1'b0, 1'b1, 32'h0000_0100, 8'h77);
            #1;
            checks++;
            if (ram_we !== 1'b0) begin
                errors++; $display("FAIL gated_ram_we%0d: got %b expected 0", i, ram_we);
            end
            cycle();
        end
        repeat (5) begin
            bus(1'b0, 1'b1, 32'h0003_0000, 8'h77);
            cycle();
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL gated_push: tx_valid=%b expected 0", tx_valid);
        end
        bus(1'b1, 1'b0, 32'h0003_0004, 8'h00);
        cycle();
        checks++;
        if (cpu_din !== 8'h05) begin
            errors++; $display("FAIL gated_counter: got %h expected 05", cpu_din);
        end
        bus(1'b1, 1'b0, 32'h0000_0100, 8'h00);
        cycle();
        checks++;
        if (cpu_din !== 8'h41) begin
            errors++; $display("FAIL gated_ram_kept: got %h expected 41", cpu_din);
        end
    endtask

    task automatic test_finish_rx_reset();
        int start;
        do_reset();
        tx_ready = 1'b1;
        start = got_q.size();
        bus(1'b1, 1'b1, 32'h0003_0004, 8'hAB);
        cycle();
        bus(1'b0, 1'b0, 32'h0, 8'h00);
        checks++;
        if (program_finish !== 1'b1) begin
            errors++; $display("FAIL finish_set: got %b expected 1", program_finish);
        end
        repeat (4) cycle();
        checks++;
        if (program_finish !== 1'b1) begin
            errors++; $display("FAIL finish_sticky: got %b expected 1", program_finish);
        end
        checks++;
        if (got_q.size() - start !== 1) begin
            errors++; $display("FAIL finish_zero_count: got %0d bytes expected 1", got_q.size() - start);
        end else begin
            checks++;
            if (got_q[start] !== 8'h00) begin
                errors++; $display("FAIL finish_zero_byte: got %h expected 00", got_q[start]);
            end
        end
        tx_ready = 1'b0;
        bus(1'b1, 1'b1, 32'h0003_0000, 8'h41);
        cycle();
        bus(1'b1, 1'b0, 32'h0003_0000, 8'h00);
        #1;
        checks++;
        if (rx_pop !== 1'b0) begin
            errors++; $display("FAIL rx_pop_empty: got %b expected 0", rx_pop);
        end
        cycle();
        checks++;
        if (cpu_din !== 8'h00) begin
            errors++; $display("FAIL rx_read_empty: got %h expected 00", cpu_din);
        end
        rx_valid = 1'b1; rx_data = 8'h5A;
        #1;
        checks++;
        if (rx_pop !== 1'b1) begin
            errors++; $display("FAIL rx_pop: got %b expected 1", rx_pop);
        end
        cycle();
        bus(1'b0, 1'b0, 32'h0003_0000, 8'h00);
        #1;
        checks++;
        if ({cpu_din, rx_pop, tx_valid} !== {8'h5A, 1'b0, 1'b1}) begin
            errors++; $display("FAIL rx_read: din=%h pop=%b txv=%b expected 5a 0 1", cpu_din, rx_pop, tx_valid);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({cpu_din, tx_data, program_finish, tx_valid, io_buffer_full, tx_overflow} !== 20'h0) begin
            errors++;
            $display("FAIL async_reset: din=%h txd=%h pf=%b txv=%b ibf=%b ovf=%b expected all 0",
                     cpu_din, tx_data, program_finish, tx_valid, io_buffer_full, tx_overflow);
        end
        rx_valid = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_ram();
        test_tx_basic();
        test_fifo_full();
        test_counter();
        test_rdy_gating();
        test_finish_rx_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
